sd_data_xfer_sched: RTL and testbench
=====================================

// Module: sd_data_xfer_sched
// PURPOSE
//  Parametrised successor of the data-transfer trigger. Arms on a data-carrying command.
//  Gates start_tx/start_rx on command completion, a programmable write gap and data-path idle.
//  Reports command error, response timeout and abort.
//  Sits between the command master (sd_cmd_master) and the data serial host, in the sd_clk domain.
// PARAMETERS
//  TX_DELAY     2    sd_clk cycles inserted between CMD_CC sample and start_tx (Nwr gap); 0..15
//  RX_AFTER_CC  0    0: start_rx right after command issue (legacy); 1: start_rx only after CMD_CC
//  TMO_W        16   width of response timeout counter / cmd_timeout_i
// PORTS
//  sd_clk                 in   1            SD clock; all logic on rising edge
//  rst                    in   1            reset, synchronous, active-high
//  cmd_with_data_start_i  in   1            request: command with data phase issued
//  r_w_i                  in   1            1 = read (card->host), 0 = write; sampled with request
//  cmd_int_status_i       in   `INT_CMD_SIZE  command status; bits `INT_CMD_CC, `INT_CMD_EI used
//  cmd_timeout_i          in   TMO_W        response timeout in sd_clk cycles; 0 = disabled
//  data_busy_i            in   1            data path busy; start pulses held while 1
//  abort_i                in   1            cancel pending transfer
//  start_tx_o             out  1            one-cycle pulse: begin write data phase
//  start_rx_o             out  1            one-cycle pulse: begin read data phase
//  busy_o                 out  1            1 whenever state != IDLE
//  err_o                  out  1            one-cycle pulse: transfer dropped
//  err_code_o             out  2            00 none, 01 CMD_EI, 10 timeout, 11 abort; held until next request
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. rst mid-operation drops the transfer silently (no err_o).
//  States: IDLE, WAIT_CMD, DELAY, WAIT_DATA.
//  IDLE: cmd_with_data_start_i=1 latches r_w_i, clears err_code_o.
//   read & RX_AFTER_CC=0 -> WAIT_DATA.
//   otherwise -> WAIT_CMD, timeout counter loaded from cmd_timeout_i.
//  WAIT_CMD priority: abort_i > EI > CC > timeout.
//   abort -> IDLE, err 11. EI -> IDLE, err 01 (EI wins over simultaneous CC).
//   CC -> DELAY (write, TX_DELAY>0) else WAIT_DATA. Counter hitting 0 (nonzero load) -> IDLE, err 10.
//  DELAY: counts TX_DELAY cycles, then WAIT_DATA; abort_i -> IDLE, err 11.
//  WAIT_DATA: first cycle with data_busy_i=0 -> pulse start_tx_o (write) or start_rx_o (read), then IDLE.
//   abort_i -> IDLE, err 11, no pulse.
//  Latency, data idle: legacy read accepted at edge E -> start_rx_o high E+1..E+2.
//   Write with CC sampled at edge C -> start_tx_o high C+1+TX_DELAY for exactly one cycle.
//  start_tx_o and start_rx_o never both high; each pulse exactly one cycle; registered outputs.
//  cmd_with_data_start_i while busy_o=1 is ignored (no queueing).
//  CC/EI seen in IDLE, DELAY or WAIT_DATA are ignored.
//  Timeout counter saturates at 0 (no wrap); cmd_timeout_i only sampled on request.
// CONFIGURATION
//  SD_XFER_SCHED_TIMEOUT_EN defined: timeout counter present; err code 10 reachable.
//  Undefined: counter removed, cmd_timeout_i unused, WAIT_CMD waits indefinitely for CC/EI/abort.
// STRUCTURE
//  Package sd_xfer_sched_pkg: state enum (IDLE/WAIT_CMD/DELAY/WAIT_DATA), err_code_t enum (NONE/CMD_EI/TMO/ABORT).
//  CMD_CC/EI bit indices stay in sd_defines.h.
//  Sub-module sd_xfer_down_counter (load, enable, zero flag; parametrised width).
//   One instance for TX_DELAY, one for timeout (timeout only under macro).
// TESTING
//  1 Read, RX_AFTER_CC=0: req+r_w=1 one cycle -> start_rx_o=1 next cycle only; later CC -> no pulse, err_o=0.
//  2 Write, TX_DELAY=2: req, CC 4 cycles later -> start_tx_o high exactly 3 cycles after CC edge; busy_o falls after.
//  3 Write, EI and CC same cycle -> err_o pulse, err_code_o=01, no start_tx_o.
//  4 Macro on, cmd_timeout_i=10, no CC -> err_o at cycle 10 after request, err_code_o=10.
//    Macro off -> busy_o stays 1 until abort.
//  5 Write with data_busy_i=1 for 5 cycles after delay expiry -> start_tx_o in first cycle after busy drops.
//  6 abort_i in DELAY -> err_code_o=11, no start pulse.
//    rst in WAIT_DATA -> all outputs 0 next cycle, no err_o.

Source files
------------

// File: rtl/sd_xfer_sched_pkg.sv
// Shared types for the SD data-transfer scheduler: FSM states and error codes.
package sd_xfer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CMD  = 2'd1,
    DELAY     = 2'd2,
    WAIT_DATA = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    CMD_EI = 2'b01,
    TMO    = 2'b10,
    ABORT  = 2'b11
  } err_code_t;

  localparam int unsigned DLY_W = 4;

endpackage

// File: rtl/sd_xfer_down_counter.sv
// Loadable down counter that saturates at zero; zero flag reflects the current count.
module sd_xfer_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sd_data_xfer_sched.sv
// Data-transfer scheduler: gates start_tx/start_rx on command completion, Nwr gap and data idle.
// Optional response timeout enabled by defining SD_XFER_SCHED_TIMEOUT_EN.
`ifndef INT_CMD_SIZE
`define INT_CMD_SIZE 5
`endif
`ifndef INT_CMD_CC
`define INT_CMD_CC 0
`endif
`ifndef INT_CMD_EI
`define INT_CMD_EI 1
`endif

module sd_data_xfer_sched
  import sd_xfer_sched_pkg::*;
#(
  parameter int unsigned TX_DELAY    = 2,
  parameter bit          RX_AFTER_CC = 1'b0,
  parameter int unsigned TMO_W       = 16
) (
  input  logic                     sd_clk,
  input  logic                     rst,
  input  logic                     cmd_with_data_start_i,
  input  logic                     r_w_i,
  input  logic [`INT_CMD_SIZE-1:0] cmd_int_status_i,
  input  logic [TMO_W-1:0]         cmd_timeout_i,
  input  logic                     data_busy_i,
  input  logic                     abort_i,
  output logic                     start_tx_o,
  output logic                     start_rx_o,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o
);

  localparam bit             DLY_EN   = (TX_DELAY != 0);
  // Counter holds TX_DELAY-1 so the zero check in the last DELAY cycle lands on C+TX_DELAY.
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_EN ? DLY_W'(TX_DELAY - 1) : '0;

  state_t    state, state_n;
  err_code_t code, code_n;
  logic      rw, rw_n;
  logic      tx_n, rx_n, err_n;
  logic      dly_load, dly_zero;
  logic      tmo_load, tmo_hit;
  logic      cc, ei;
  logic      unused_status;

  assign cc            = cmd_int_status_i[`INT_CMD_CC];
  assign ei            = cmd_int_status_i[`INT_CMD_EI];
  assign unused_status = ^cmd_int_status_i;

  sd_xfer_down_counter #(.W(DLY_W)) u_dly_cnt (
    .clk      (sd_clk),
    .rst      (rst),
    .load     (dly_load),
    .en       (state == DELAY),
    .load_val (DLY_LOAD),
    .zero     (dly_zero)
  );

`ifdef SD_XFER_SCHED_TIMEOUT_EN
  logic tmo_armed, tmo_zero;

  // Loaded with timeout-1 so expiry fires on the edge exactly cmd_timeout_i cycles after the request.
  sd_xfer_down_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk      (sd_clk),
    .rst      (rst),
    .load     (tmo_load),
    .en       (state == WAIT_CMD),
    .load_val (cmd_timeout_i - TMO_W'(1)),
    .zero     (tmo_zero)
  );

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      tmo_armed <= 1'b0;
    end else if (tmo_load) begin
      tmo_armed <= (cmd_timeout_i != '0);
    end
  end

  assign tmo_hit = tmo_armed & tmo_zero;
`else
  logic unused_tmo;

  assign unused_tmo = ^{cmd_timeout_i, tmo_load};
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    rw_n     = rw;
    code_n   = code;
    tx_n     = 1'b0;
    rx_n     = 1'b0;
    err_n    = 1'b0;
    dly_load = 1'b0;
    tmo_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_with_data_start_i) begin
          rw_n   = r_w_i;
          code_n = NONE;
          if (r_w_i && !RX_AFTER_CC) begin
            state_n = WAIT_DATA;
          end else begin
            state_n  = WAIT_CMD;
            tmo_load = 1'b1;
          end
        end
      end
      WAIT_CMD: begin
        if (abort_i) begin
          state_n = IDLE;
          code_n  = ABORT;
          err_n   = 1'b1;
        end else if (ei) begin
          state_n = IDLE;
          code_n  = CMD_EI;
          err_n   = 1'b1;
        end else if (cc) begin
          if (!rw && DLY_EN) begin
            state_n  = DELAY;
            dly_load = 1'b1;
          end else begin
            state_n = WAIT_DATA;
          end
        end else if (tmo_hit) begin
          state_n = IDLE;
          code_n  = TMO;
          err_n   = 1'b1;
        end
      end
      DELAY: begin
        if (abort_i) begin
          state_n = IDLE;
          code_n  = ABORT;
          err_n   = 1'b1;
        end else if (dly_zero) begin
          state_n = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (abort_i) begin
          state_n = IDLE;
          code_n  = ABORT;
          err_n   = 1'b1;
        end else if (!data_busy_i) begin
          state_n = IDLE;
          tx_n    = !rw;
          rx_n    = rw;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state      <= IDLE;
      code       <= NONE;
      rw         <= 1'b0;
      start_tx_o <= 1'b0;
      start_rx_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_n;
      code       <= code_n;
      rw         <= rw_n;
      start_tx_o <= tx_n;
      start_rx_o <= rx_n;
      err_o      <= err_n;
    end
  end

  assign busy_o     = (state != IDLE);
  assign err_code_o = code;

endmodule

// File: tb/tb_sd_data_xfer_sched.sv
// Bench for sd_data_xfer_sched: directed table, hand sequences and random scenarios vs an event model.
`ifndef INT_CMD_SIZE
`define INT_CMD_SIZE 5
`endif
`ifndef INT_CMD_CC
`define INT_CMD_CC 0
`endif
`ifndef INT_CMD_EI
`define INT_CMD_EI 1
`endif

module tb_sd_data_xfer_sched;

  localparam int unsigned TX_DELAY    = 2;
  localparam bit          RX_AFTER_CC = 1'b0;
  localparam int unsigned TMO_W       = 16;
  localparam int          WIN         = 40;
  localparam int          INF         = 1000;
  localparam int K_NONE = 0, K_TX = 1, K_RX = 2, K_ERR = 3;
`ifdef SD_XFER_SCHED_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  // Times are edge indices relative to the request edge (0); 0 in cc_at/abort_at means "never".
  typedef struct {
    bit rw;
    int cc_at;
    bit ei;
    int abort_at;
    int busy_end;
    int tmo;
    int kind;
    int at;
    int code;
  } vec_t;

  logic                     sd_clk = 1'b0;
  logic                     rst;
  logic                     req;
  logic                     r_w;
  logic [`INT_CMD_SIZE-1:0] status;
  logic [TMO_W-1:0]         tmo_in;
  logic                     data_busy;
  logic                     abort;
  logic                     start_tx, start_rx, busy, err;
  logic [1:0]               err_code;

  int errors = 0;
  int checks = 0;

  always #5 sd_clk = ~sd_clk;

  sd_data_xfer_sched #(
    .TX_DELAY    (TX_DELAY),
    .RX_AFTER_CC (RX_AFTER_CC),
    .TMO_W       (TMO_W)
  ) dut (
    .sd_clk                (sd_clk),
    .rst                   (rst),
    .cmd_with_data_start_i (req),
    .r_w_i                 (r_w),
    .cmd_int_status_i      (status),
    .cmd_timeout_i         (tmo_in),
    .data_busy_i           (data_busy),
    .abort_i               (abort),
    .start_tx_o            (start_tx),
    .start_rx_o            (start_rx),
    .busy_o                (busy),
    .err_o                 (err),
    .err_code_o            (err_code)
  );

  function automatic void check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Outcome from the event timeline: earliest of abort/EI/CC/timeout, then gap and data-idle.
  function automatic void model(input vec_t v, output int kind, output int at, output int code);
    int a, c, t, first, p;
    a = (v.abort_at != 0) ? v.abort_at : INF;
    kind = K_NONE; at = -1; code = 0;
    if (v.rw && !RX_AFTER_CC) begin
      p = imax(1, v.busy_end);
      if (a <= p) begin kind = K_ERR; at = a; code = 3; end
      else begin kind = K_RX; at = p; end
      return;
    end
    c = (v.cc_at != 0) ? v.cc_at : INF;
    t = (TMO_ON && v.tmo != 0) ? v.tmo : INF;
    first = (a < c) ? a : c;
    first = (t < first) ? t : first;
    if (first == INF) return;
    if (a == first) begin
      kind = K_ERR; at = a; code = 3;
    end else if (c == first) begin
      if (v.ei) begin
        kind = K_ERR; at = c; code = 1;
      end else begin
        p = imax(c + 1 + ((!v.rw) ? int'(TX_DELAY) : 0), v.busy_end);
        if (a <= p) begin kind = K_ERR; at = a; code = 3; end
        else begin kind = v.rw ? K_RX : K_TX; at = p; end
      end
    end else begin
      kind = K_ERR; at = t; code = 2;
    end
  endfunction

  task automatic idle_inputs();
    req = 1'b0; r_w = 1'b0; status = '0; tmo_in = '0; data_busy = 1'b0; abort = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, output int kind, output int at, output int npulse,
                         output int code_seen, output int busy_seen);
    kind = K_NONE; at = -1; npulse = 0;
    for (int k = 0; k <= WIN; k++) begin
      @(negedge sd_clk);
      req    = (k == 0);
      r_w    = v.rw;
      status = '0;
      if (k != 0 && k == v.cc_at) begin
        status[`INT_CMD_CC] = 1'b1;
        status[`INT_CMD_EI] = v.ei;
      end
      tmo_in    = (k == 0) ? TMO_W'(v.tmo) : TMO_W'($urandom);
      abort     = (k != 0 && k == v.abort_at);
      data_busy = (k < v.busy_end);
      @(posedge sd_clk);
      #1;
      npulse += int'(start_tx) + int'(start_rx) + int'(err);
      if (kind == K_NONE) begin
        if (start_tx)      begin kind = K_TX;  at = k; end
        else if (start_rx) begin kind = K_RX;  at = k; end
        else if (err)      begin kind = K_ERR; at = k; end
      end
    end
    idle_inputs();
    code_seen = int'(err_code);
    busy_seen = int'(busy);
  endtask

  task automatic check_txn(string tag, input vec_t v, input int ekind, input int eat, input int ecode);
    int kind, at, npulse, code_seen, busy_seen;
    run_txn(v, kind, at, npulse, code_seen, busy_seen);
    check({tag, " kind"}, kind, ekind);
    check({tag, " edge"}, at, eat);
    check({tag, " pulses"}, npulse, 1);
    check({tag, " err_code"}, code_seen, ecode);
    check({tag, " busy_end"}, busy_seen, 0);
  endtask

  vec_t tbl[$];

  initial begin
    int mk, mat, mc, seen;
    vec_t v;

    tbl.push_back('{1'b1, 3, 1'b0,  0,  0,  0, K_RX,  1,  0});
    tbl.push_back('{1'b0, 4, 1'b0,  0,  0,  0, K_TX,  7,  0});
    tbl.push_back('{1'b0, 2, 1'b1,  0,  0,  0, K_ERR, 2,  1});
    tbl.push_back('{1'b0, 3, 1'b0,  0, 10,  0, K_TX, 10,  0});
    tbl.push_back('{1'b0, 3, 1'b0,  5,  0,  0, K_ERR, 5,  3});
    tbl.push_back('{1'b1, 0, 1'b0,  4,  4,  0, K_ERR, 4,  3});
    tbl.push_back('{1'b1, 2, 1'b1,  0,  5,  0, K_RX,  5,  0});
    tbl.push_back('{1'b0, 5, 1'b0,  5,  0,  0, K_ERR, 5,  3});
    tbl.push_back('{1'b0, 0, 1'b0, 20,  0, 10, K_ERR, TMO_ON ? 10 : 20, TMO_ON ? 2 : 3});
    tbl.push_back('{1'b0, 6, 1'b0,  0,  0,  6, K_TX,  9,  0});
    tbl.push_back('{1'b0, 8, 1'b0,  0,  0,  5, TMO_ON ? K_ERR : K_TX, TMO_ON ? 5 : 11, TMO_ON ? 2 : 0});
    tbl.push_back('{1'b0, 3, 1'b0,  0,  0,  1, TMO_ON ? K_ERR : K_TX, TMO_ON ? 1 : 6, TMO_ON ? 2 : 0});
    tbl.push_back('{1'b0, 4, 1'b0,  7,  0,  0, K_ERR, 7,  3});
    tbl.push_back('{1'b0, 2, 1'b0,  0,  3,  0, K_TX,  5,  0});

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge sd_clk);
    #1;
    check("reset outputs", int'({start_tx, start_rx, err, busy, err_code}), 0);
    @(negedge sd_clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      check_txn($sformatf("vec%0d", i), tbl[i], tbl[i].kind, tbl[i].at, tbl[i].code);
    end

    // Request while busy is ignored: pending read still completes as a read.
    @(negedge sd_clk);
    req = 1'b1; r_w = 1'b1; data_busy = 1'b1;
    @(negedge sd_clk);
    req = 1'b0;
    @(negedge sd_clk);
    req = 1'b1; r_w = 1'b0;
    @(posedge sd_clk); #1;
    check("ignored req busy", int'(busy), 1);
    check("ignored req no pulse", int'({start_tx, start_rx, err}), 0);
    @(negedge sd_clk);
    req = 1'b0; data_busy = 1'b0;
    @(posedge sd_clk); #1;
    check("ignored req rx/tx", int'({start_rx, start_tx}), 2);
    @(posedge sd_clk); #1;
    check("ignored req after", int'({start_rx, start_tx, busy}), 0);

    // Reset while parked in WAIT_DATA drops the transfer without an error pulse.
    @(negedge sd_clk);
    req = 1'b1; r_w = 1'b0; data_busy = 1'b1;
    @(negedge sd_clk);
    req = 1'b0; status[`INT_CMD_CC] = 1'b1;
    @(negedge sd_clk);
    status = '0;
    repeat (4) @(negedge sd_clk);
    check("pre-rst busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge sd_clk); #1;
    check("rst mid outputs", int'({start_tx, start_rx, err, busy, err_code}), 0);
    @(negedge sd_clk);
    rst = 1'b0; data_busy = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge sd_clk); #1;
      seen += int'(start_tx) + int'(start_rx) + int'(err) + int'(busy);
    end
    check("post-rst quiet", seen, 0);

    for (int n = 0; n < 40; n++) begin
      v.rw       = 1'($urandom_range(0, 1));
      v.cc_at    = int'($urandom_range(1, 8));
      v.ei       = ($urandom_range(0, 3) == 0);
      v.abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : 0;
      v.busy_end = int'($urandom_range(0, 12));
      v.tmo      = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      v.kind = 0; v.at = 0; v.code = 0;
      model(v, mk, mat, mc);
      check_txn($sformatf("rnd%0d", n), v, mk, mat, mc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
